// File: rtl/bomb_scheduler_if.sv
// Bomb scheduler bus: player requests/positions in, slot status and bomb-map write port out.
interface bomb_scheduler_if;
  logic       tick;
  logic       reqA;
  logic       reqB;
  logic [3:0] playerAx;
  logic [3:0] playerAy;
  logic [3:0] playerBx;
  logic [3:0] playerBy;
  logic [3:0] bombA_x;
  logic [3:0] bombA_y;
  logic [3:0] bombB_x;
  logic [3:0] bombB_y;
  logic       bombA_v;
  logic       bombB_v;
  logic       blastA;
  logic       blastB;
  logic       wr_en;
  logic [6:0] wr_idx;
  logic [1:0] wr_data;

  modport master (
    output tick, reqA, reqB, playerAx, playerAy, playerBx, playerBy,
    input  bombA_x, bombA_y, bombB_x, bombB_y, bombA_v, bombB_v,
    input  blastA, blastB, wr_en, wr_idx, wr_data
  );

  modport slave (
    input  tick, reqA, reqB, playerAx, playerAy, playerBx, playerBy,
    output bombA_x, bombA_y, bombB_x, bombB_y, bombA_v, bombB_v,
    output blastA, blastB, wr_en, wr_idx, wr_data
  );
endinterface

// File: rtl/bomb_scheduler.sv
// Two-slot bomb scheduler: place -> fuse -> blast -> clear per player, with a
// round-robin arbitrated single write port into the 2-bit-per-cell bomb map.
// Optional macro BOMB_CHAIN_REACTION_EN: a blast detonates the other slot's
// armed bomb if it sits in the blast cross (same row/column, distance 1).
module bomb_scheduler #(
  parameter int unsigned GRID        = 10,
  parameter int unsigned FUSE_TICKS  = 3,
  parameter int unsigned BLAST_TICKS = 1
) (
  input logic            clk,
  input logic            rst,
  bomb_scheduler_if.slave bus
);

  localparam int unsigned CNT_MAX = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = 7;
  localparam int unsigned CRD_W   = 4;
  localparam int unsigned DAT_W   = 2;

  localparam logic [DAT_W-1:0] WR_PLACE = 2'b01;
  localparam logic [DAT_W-1:0] WR_BLAST = 2'b10;
  localparam logic [DAT_W-1:0] WR_CLEAR = 2'b00;

  typedef enum logic [1:0] {IDLE, ARMED, BLAST} slot_state_e;

  // Slot 0 is player A, slot 1 is player B.
  slot_state_e        state_q [2];
  slot_state_e        state_d [2];
  logic [CNT_W-1:0]   cnt_q   [2];
  logic [CNT_W-1:0]   cnt_d   [2];
  logic [CRD_W-1:0]   x_q     [2];
  logic [CRD_W-1:0]   x_d     [2];
  logic [CRD_W-1:0]   y_q     [2];
  logic [CRD_W-1:0]   y_d     [2];
  logic [1:0]         v_q, v_d;
  logic [1:0]         blast_q, blast_d;
  logic [1:0]         pv_q, pv_d;
  logic [IDX_W-1:0]   pidx_q  [2];
  logic [IDX_W-1:0]   pidx_d  [2];
  logic [DAT_W-1:0]   pdata_q [2];
  logic [DAT_W-1:0]   pdata_d [2];
  logic               ptr_q, ptr_d;
  logic               wr_en_q, wr_en_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [DAT_W-1:0]   wr_data_q, wr_data_d;

  logic [1:0]         req;
  logic [CRD_W-1:0]   px [2];
  logic [CRD_W-1:0]   py [2];
  logic [1:0]         acc;
  logic               conflict;
  logic               contested;
  logic               grant;

`ifdef BOMB_CHAIN_REACTION_EN
  logic [1:0]         entered_q, entered_d;
  logic [1:0]         det;
`endif

  assign req   = {bus.reqB, bus.reqA};
  assign px[0] = bus.playerAx;
  assign py[0] = bus.playerAy;
  assign px[1] = bus.playerBx;
  assign py[1] = bus.playerBy;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [CRD_W-1:0] x,
                                                input logic [CRD_W-1:0] y);
    return IDX_W'(y) * IDX_W'(GRID) + IDX_W'(x);
  endfunction

  function automatic logic coord_ok(input logic [CRD_W-1:0] x, input logic [CRD_W-1:0] y);
    return (32'(x) < GRID) && (32'(y) < GRID);
  endfunction

`ifdef BOMB_CHAIN_REACTION_EN
  function automatic logic in_cross(input logic [CRD_W-1:0] ax, input logic [CRD_W-1:0] ay,
                                    input logic [CRD_W-1:0] bx, input logic [CRD_W-1:0] by);
    return ((ax == bx) && ((by == ay + CRD_W'(1)) || (ay == by + CRD_W'(1)))) ||
           ((ay == by) && ((bx == ax + CRD_W'(1)) || (ax == bx + CRD_W'(1))));
  endfunction
`endif

  // Next-state: request acceptance, fuse/blast sequencing, pending writes, write arbitration.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      pidx_d[i]  = pidx_q[i];
      pdata_d[i] = pdata_q[i];
    end
    pv_d      = pv_q;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    acc       = '0;
    conflict  = 1'b0;
    contested = 1'b0;
    grant     = 1'b0;
`ifdef BOMB_CHAIN_REACTION_EN
    entered_d = '0;
    det       = '0;
`endif

    for (int i = 0; i < 2; i++) begin
      acc[i] = req[i] && (state_q[i] == IDLE) && coord_ok(px[i], py[i]) &&
               !((state_q[1-i] != IDLE) && (x_q[1-i] == px[i]) && (y_q[1-i] == py[i]));
`ifdef BOMB_CHAIN_REACTION_EN
      det[i] = entered_q[1-i] && (state_q[i] == ARMED) &&
               in_cross(x_q[1-i], y_q[1-i], x_q[i], y_q[i]);
`endif
    end

    // Both players claiming the same free cell: the pointer slot keeps it.
    conflict = acc[0] && acc[1] && (px[0] == px[1]) && (py[0] == py[1]);
    if (conflict) begin
      if (ptr_q) acc[0] = 1'b0;
      else       acc[1] = 1'b0;
    end

    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        state_d[i] = ARMED;
        x_d[i]     = px[i];
        y_d[i]     = py[i];
        cnt_d[i]   = CNT_W'(FUSE_TICKS);
        pv_d[i]    = 1'b1;
        pidx_d[i]  = cell_idx(px[i], py[i]);
        pdata_d[i] = WR_PLACE;
`ifdef BOMB_CHAIN_REACTION_EN
      end else if (det[i]) begin
        state_d[i]   = BLAST;
        cnt_d[i]     = CNT_W'(BLAST_TICKS);
        pv_d[i]      = 1'b1;
        pidx_d[i]    = cell_idx(x_q[i], y_q[i]);
        pdata_d[i]   = WR_BLAST;
        entered_d[i] = 1'b1;
`endif
      end else if (bus.tick) begin
        case (state_q[i])
          ARMED: begin
            if (cnt_q[i] == CNT_W'(1)) begin
              state_d[i] = BLAST;
              cnt_d[i]   = CNT_W'(BLAST_TICKS);
              pv_d[i]    = 1'b1;
              pidx_d[i]  = cell_idx(x_q[i], y_q[i]);
              pdata_d[i] = WR_BLAST;
`ifdef BOMB_CHAIN_REACTION_EN
              entered_d[i] = 1'b1;
`endif
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          BLAST: begin
            if (cnt_q[i] == CNT_W'(1)) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
              pv_d[i]    = 1'b1;
              pidx_d[i]  = cell_idx(x_q[i], y_q[i]);
              pdata_d[i] = WR_CLEAR;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end

    // One grant per cycle; the pointer slot wins when both are pending.
    if (pv_d[0] && pv_d[1]) begin
      contested = 1'b1;
      grant     = ptr_q;
    end else begin
      grant = pv_d[1];
    end
    if (pv_d[0] || pv_d[1]) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = pidx_d[grant];
      wr_data_d = pdata_d[grant];
      pv_d[grant] = 1'b0;
    end

    ptr_d = ptr_q ^ (conflict | contested);

    for (int i = 0; i < 2; i++) begin
      v_d[i]     = (state_d[i] != IDLE);
      blast_d[i] = (state_d[i] == BLAST);
    end
  end

  // State and output registers; reset aborts everything without clear writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        pidx_q[i]  <= '0;
        pdata_q[i] <= '0;
      end
      v_q       <= '0;
      blast_q   <= '0;
      pv_q      <= '0;
      ptr_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
`ifdef BOMB_CHAIN_REACTION_EN
      entered_q <= '0;
`endif
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        pidx_q[i]  <= pidx_d[i];
        pdata_q[i] <= pdata_d[i];
      end
      v_q       <= v_d;
      blast_q   <= blast_d;
      pv_q      <= pv_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
`ifdef BOMB_CHAIN_REACTION_EN
      entered_q <= entered_d;
`endif
    end
  end

  assign bus.bombA_x = x_q[0];
  assign bus.bombA_y = y_q[0];
  assign bus.bombB_x = x_q[1];
  assign bus.bombB_y = y_q[1];
  assign bus.bombA_v = v_q[0];
  assign bus.bombB_v = v_q[1];
  assign bus.blastA  = blast_q[0];
  assign bus.blastB  = blast_q[1];
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_idx  = wr_idx_q;
  assign bus.wr_data = wr_data_q;

endmodule
